// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//    Round-robin write arbiter and sequencer for a shared bank of byte
//    registers. Four requesters compete for single-port write access.
//    Each accepted request runs IDLE -> GRANT -> DONE:
//    - GRANT performs the write.
//    - DONE pulses ACK for the winner and may start the next grant back-to-back.
//
// Parameters
//    NUM_REG : number of byte registers (1..8)
//    ADDR_W  : register address width
//
// Ports
//    CLK    : clock, rising edge
//    RST    : asynchronous reset, active-high
//    REQ    : per-requester level request, held until ACK
//    ADDR   : per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//    WDATA  : per-requester byte, requester i at [i*8 +: 8]
//    LOCK   : (REG_ARB_LOCK_EN only) per-requester re-grant hold
//    ACK    : one-cycle one-hot write-complete pulse
//    GNT_ID : current or last granted requester
//    BUSY   : high in GRANT and DONE
//    DOUT   : bank contents, register r at [r*8 +: 8]
//
// Optional feature macro: REG_ARB_LOCK_EN
//    When defined, a locked requester that still requests in DONE is
//    re-granted directly, without round-robin and without advancing LAST.
module reg_bank_arbiter #(
   parameter int NUM_REG = 8,
   parameter int ADDR_W  = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [3:0]            REQ,
   input  logic [4*ADDR_W-1:0]   ADDR,
   input  logic [31:0]           WDATA,
`ifdef REG_ARB_LOCK_EN
   input  logic [3:0]            LOCK,
`endif
   output logic [3:0]            ACK,
   output logic [1:0]            GNT_ID,
   output logic                  BUSY,
   output logic [8*NUM_REG-1:0]  DOUT
);

   typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

   state_t              state_reg;
   logic [1:0]          last_reg;
   logic [1:0]          gnt_id_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [7:0]          wdata_reg;
   logic [3:0]          ack_reg;
   logic                busy_reg;
   logic [7:0]          bank_reg [NUM_REG];

   logic [3:0]          mask_vec;
   logic [3:0]          valid_vec;
   logic [1:0]          cand_id;
   logic [1:0]          win_id;
   logic                win_found;
   logic                relock;
   logic                take;
   logic [1:0]          cap_id;

   // Round-robin search starting just after LAST. In DONE the requester
   // being acknowledged is masked, so its still-high REQ is not a new request.
   always_comb begin
      mask_vec = '0;
      if (state_reg == DONE)
         mask_vec[gnt_id_reg] = 1'b1;
      valid_vec = REQ & ~mask_vec;
      win_found = 1'b0;
      win_id    = last_reg;
      cand_id   = last_reg;
      for (int k = 1; k <= 4; k++) begin
         cand_id = last_reg + 2'(k);   // k=4 wraps back to LAST itself
         if (!win_found && valid_vec[cand_id]) begin
            win_found = 1'b1;
            win_id    = cand_id;
         end
      end
   end

`ifdef REG_ARB_LOCK_EN
   assign relock = (state_reg == DONE) && LOCK[gnt_id_reg] && REQ[gnt_id_reg];
`else
   assign relock = 1'b0;
`endif

   // A lock re-grant takes precedence over normal arbitration.
   assign take   = relock || win_found;
   assign cap_id = relock ? gnt_id_reg : win_id;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg  <= IDLE;
         last_reg   <= 2'd3;
         gnt_id_reg <= 2'd0;
         addr_reg   <= '0;
         wdata_reg  <= 8'h00;
         ack_reg    <= 4'b0000;
         busy_reg   <= 1'b0;
      end else begin
         case (state_reg)
            GRANT: begin
               last_reg  <= gnt_id_reg;
               ack_reg   <= 4'b0001 << gnt_id_reg;
               busy_reg  <= 1'b1;
               state_reg <= DONE;
            end
            default: begin   // IDLE and DONE arbitrate identically
               ack_reg <= 4'b0000;
               if (take) begin
                  gnt_id_reg <= cap_id;
                  addr_reg   <= ADDR[cap_id*ADDR_W +: ADDR_W];
                  wdata_reg  <= WDATA[cap_id*8 +: 8];
                  busy_reg   <= 1'b1;
                  state_reg  <= GRANT;
               end else begin
                  busy_reg   <= 1'b0;
                  state_reg  <= IDLE;
               end
            end
         endcase
      end
   end

   // One register per byte. An address that matches no register
   // (ADDR >= NUM_REG) simply writes nothing.
   generate
      for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_bank
         always_ff @(posedge CLK or posedge RST) begin
            if (RST)
               bank_reg[gi] <= 8'h00;
            else if (state_reg == GRANT && addr_reg == ADDR_W'(gi))
               bank_reg[gi] <= wdata_reg;
         end
         assign DOUT[gi*8 +: 8] = bank_reg[gi];
      end
   endgenerate

   assign ACK    = ack_reg;
   assign GNT_ID = gnt_id_reg;
   assign BUSY   = busy_reg;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;

   logic        CLK;
   logic        RST;
   logic [3:0]  REQ;
   logic [11:0] ADDR;
   logic [31:0] WDATA;
`ifdef REG_ARB_LOCK_EN
   logic [3:0]  LOCK;
`endif
   logic [3:0]  ACK8, ACK4;
   logic [1:0]  GNT8, GNT4;
   logic        BUSY8, BUSY4;
   logic [63:0] DOUT8;
   logic [31:0] DOUT4;

   reg_bank_arbiter #(.NUM_REG(8), .ADDR_W(3)) dut8 (
      .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR(ADDR), .WDATA(WDATA),
`ifdef REG_ARB_LOCK_EN
      .LOCK(LOCK),
`endif
      .ACK(ACK8), .GNT_ID(GNT8), .BUSY(BUSY8), .DOUT(DOUT8));

   reg_bank_arbiter #(.NUM_REG(4), .ADDR_W(3)) dut4 (
      .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR(ADDR), .WDATA(WDATA),
`ifdef REG_ARB_LOCK_EN
      .LOCK(LOCK),
`endif
      .ACK(ACK4), .GNT_ID(GNT4), .BUSY(BUSY4), .DOUT(DOUT4));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Per-requester scripts: a list of writes, served in order, REQ held while any remain.
   logic [2:0] s_addr [4][4];
   logic [7:0] s_data [4][4];
   int         s_len  [4];
   int         s_pos  [4];
   logic [3:0] lock_en;

   // ACK log
   int         log_id  [16];
   int         log_cyc [16];
   int         log_gnt [16];
   int         nacks;
   int         cyc;
   int         busy_cnt;
   logic [3:0] ack_prev;

   typedef struct {
      int          rid;
      logic [2:0]  addr;
      logic [7:0]  data;
      logic [63:0] exp8;
      logic [31:0] exp4;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_scripts();
      for (int i = 0; i < 4; i++) begin
         s_len[i] = 0;
         s_pos[i] = 0;
      end
      lock_en = 4'b0000;
   endtask

   task automatic push(input int rid, input logic [2:0] a, input logic [7:0] d);
      s_addr[rid][s_len[rid]] = a;
      s_data[rid][s_len[rid]] = d;
      s_len[rid]++;
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         REQ[i] = (s_pos[i] < s_len[i]);
         if (s_pos[i] < s_len[i]) begin
            ADDR[i*3 +: 3]  = s_addr[i][s_pos[i]];
            WDATA[i*8 +: 8] = s_data[i][s_pos[i]];
         end
`ifdef REG_ARB_LOCK_EN
         LOCK[i] = lock_en[i] && (s_pos[i] < s_len[i]);
`endif
      end
   endtask

   // One clock cycle: sample at the falling edge, log ACK, advance scripts.
   task automatic step();
      int id;
      @(negedge CLK);
      cyc++;
      if (BUSY8) busy_cnt++;
      if (ACK8 != 4'b0000) begin
         id = 0;
         for (int i = 0; i < 4; i++) if (ACK8[i]) id = i;
         check("ack_onehot", 64'($onehot(ACK8)), 64'd1);
         check("ack_not_consecutive", 64'(ack_prev), 64'd0);
         check("ack_dut4_match", 64'(ACK4), 64'(ACK8));
         check("gnt_dut4_match", 64'(GNT4), 64'(GNT8));
         $display("ack id=%0d cyc=%0d gnt=%0d dout8=%h dout4=%h", id, cyc, GNT8, DOUT8, DOUT4);
         if (nacks < 16) begin
            log_id[nacks]  = id;
            log_cyc[nacks] = cyc;
            log_gnt[nacks] = int'(GNT8);
         end
         nacks++;
         if (s_pos[id] < s_len[id]) s_pos[id]++;
      end
      ack_prev = ACK8;
      drive();
   endtask

   task automatic run_until(input int target, input int budget);
      int n = 0;
      while (nacks < target && n < budget) begin
         step();
         n++;
      end
      check("ack_count_within_budget", 64'(nacks), 64'(target));
   endtask

   task automatic reset_assert();
      RST = 1'b1;
      clear_scripts();
      REQ = 4'b0000;
      ADDR = '0;
      WDATA = '0;
`ifdef REG_ARB_LOCK_EN
      LOCK = 4'b0000;
`endif
      ack_prev = 4'b0000;
      nacks = 0;
      @(negedge CLK);
   endtask

   task automatic reset_release();
      drive();
      @(negedge CLK);
      RST = 1'b0;
      cyc = 0;
   endtask

   int exp_ids [4];

   initial begin
      vecs[0] = '{0, 3'd2, 8'hA5, 64'h0000_0000_00A5_0000, 32'h00A5_0000};
      vecs[1] = '{3, 3'd7, 8'h3C, 64'h3C00_0000_00A5_0000, 32'h00A5_0000};
      vecs[2] = '{1, 3'd6, 8'hFF, 64'h3CFF_0000_00A5_0000, 32'h00A5_0000};
      vecs[3] = '{2, 3'd0, 8'h5A, 64'h3CFF_0000_00A5_005A, 32'h00A5_005A};
      vecs[4] = '{0, 3'd2, 8'h11, 64'h3CFF_0000_0011_005A, 32'h0011_005A};
      vecs[5] = '{1, 3'd3, 8'h80, 64'h3CFF_0000_8011_005A, 32'h8011_005A};

      cyc = 0;
      busy_cnt = 0;
      reset_assert();
      @(negedge CLK);
      check("reset_ack", 64'(ACK8), 64'd0);
      check("reset_busy", 64'(BUSY8), 64'd0);
      check("reset_busy4", 64'(BUSY4), 64'd0);
      check("reset_gnt", 64'(GNT8), 64'd0);
      check("reset_dout8", DOUT8, 64'd0);
      check("reset_dout4", 64'(DOUT4), 64'd0);
      reset_release();

      // Single writes, including out-of-range ones for the 4-register bank
      for (int v = 0; v < 6; v++) begin
         int start;
         int n0;
         start = cyc;
         n0 = nacks;
         push(vecs[v].rid, vecs[v].addr, vecs[v].data);
         drive();
         busy_cnt = 0;
         run_until(n0 + 1, 10);
         check("vec_ack_id", 64'(log_id[n0]), 64'(vecs[v].rid));
         check("vec_gnt_id", 64'(log_gnt[n0]), 64'(vecs[v].rid));
         check("vec_latency", 64'(log_cyc[n0] - start), 64'd2);
         check("vec_dout8", DOUT8, vecs[v].exp8);
         check("vec_dout4", 64'(DOUT4), 64'(vecs[v].exp4));
         step();
         check("vec_busy_cycles", 64'(busy_cnt), 64'd2);
         check("vec_idle_ack", 64'(ACK8), 64'd0);
      end

      // Contention: all four held from reset
      reset_assert();
      for (int i = 0; i < 4; i++) push(i, 3'(i), 8'h10 + 8'(i));
      reset_release();
      run_until(4, 30);
      for (int k = 0; k < 4; k++) check("contention_order", 64'(log_id[k]), 64'(k));
      for (int k = 1; k < 4; k++) check("contention_spacing", 64'(log_cyc[k] - log_cyc[k-1]), 64'd2);
      check("contention_dout8", DOUT8, 64'h0000_0000_1312_1110);
      check("contention_dout4", 64'(DOUT4), 64'h1312_1110);

      // Fairness: requester 1 continuous, requester 3 once
      reset_assert();
      push(1, 3'd4, 8'h41);
      push(1, 3'd5, 8'h42);
      push(3, 3'd6, 8'h63);
      reset_release();
      run_until(3, 30);
      exp_ids = '{1, 3, 1, 0};
      for (int k = 0; k < 3; k++) begin
         check("fair_ack_order", 64'(log_id[k]), 64'(exp_ids[k]));
         check("fair_gnt_seq", 64'(log_gnt[k]), 64'(exp_ids[k]));
      end
      check("fair_dout8", DOUT8, 64'h0063_4241_0000_0000);
      check("fair_dout4", 64'(DOUT4), 64'd0);

      // Reset in GRANT
      reset_assert();
      reset_release();
      push(2, 3'd0, 8'h22);
      drive();
      run_until(1, 10);
      step();
      check("rst_pre_dout8", DOUT8, 64'h22);
      push(1, 3'd1, 8'h99);
      push(3, 3'd3, 8'h33);
      drive();
      step();
      check("rst_grant_gnt", 64'(GNT8), 64'd3);
      check("rst_grant_busy", 64'(BUSY8), 64'd1);
      RST = 1'b1;
      #1;
      check("rst_mid_ack", 64'(ACK8), 64'd0);
      check("rst_mid_busy", 64'(BUSY8), 64'd0);
      check("rst_mid_gnt", 64'(GNT8), 64'd0);
      check("rst_mid_dout8", DOUT8, 64'd0);
      check("rst_mid_dout4", 64'(DOUT4), 64'd0);
      @(negedge CLK);
      check("rst_hold_ack", 64'(ACK8), 64'd0);
      RST = 1'b0;
      ack_prev = 4'b0000;
      nacks = 0;
      run_until(2, 20);
      check("rst_after_first", 64'(log_id[0]), 64'd1);
      check("rst_after_second", 64'(log_id[1]), 64'd3);
      check("rst_after_dout8", DOUT8, 64'h0000_0000_3300_9900);
      check("rst_after_dout4", 64'(DOUT4), 64'h3300_9900);

      // Requester 2 writes three times, requester 0 joins during its first GRANT
      reset_assert();
      reset_release();
      lock_en[2] = 1'b1;
      push(2, 3'd4, 8'hC0);
      push(2, 3'd5, 8'hC1);
      push(2, 3'd6, 8'hC2);
      drive();
      step();
      push(0, 3'd7, 8'h70);
      drive();
      run_until(4, 30);
`ifdef REG_ARB_LOCK_EN
      exp_ids = '{2, 2, 2, 0};
`else
      exp_ids = '{2, 0, 2, 2};
`endif
      for (int k = 0; k < 4; k++) check("lock_ack_order", 64'(log_id[k]), 64'(exp_ids[k]));
      check("lock_dout8", DOUT8, 64'h70C2_C1C0_0000_0000);
      check("lock_dout4", 64'(DOUT4), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
